ins_mem_fetch: RTL and testbench
================================

Name: ins_mem_fetch

Overview:
- Parametrised instruction memory with a valid/ready fetch port and a program-load port.
- After reset, a sweep state machine clears the upper region of the memory to NOP (32'h0000_0000) while the program region is preserved.
- Fetches use a registered, 1-cycle-latency read, so the block can feed the IF stage of the pipelined core directly.
- Sits between the PC register and the IF/ID pipeline register.

Parameters:
- DATA_W, 32, instruction width in bits.
- DEPTH, 32, number of words; power of 2, minimum 4.
- CLEAR_BASE, 8, first word index cleared by the post-reset sweep; words below it are preserved.
- ADDR_W, $clog2(DEPTH), word index width; derived, do not override.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  fetch request accepted this cycle.
- req_pc  in  32  byte address of the fetch.
- rsp_valid  out  1  instruction response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_instr  out  DATA_W  fetched instruction.
- rsp_err  out  1  request was misaligned or out of range.
- ld_we  in  1  program-load write strobe.
- ld_addr  in  ADDR_W  word index to load.
- ld_data  in  DATA_W  word to load.
- busy  out  1  clear sweep in progress; no fetches and no loads are accepted.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state<=CLEAR, sweep pointer<=CLEAR_BASE.
  - rsp_valid<=0, rsp_instr<=0, rsp_err<=0.
  - busy is 1 from the next cycle.
  - Memory contents below CLEAR_BASE are untouched.
- FSM state CLEAR:
  - Each cycle writes 0 to mem[ptr] and then increments ptr.
  - When ptr==DEPTH-1 is written, the next state is READY.
  - The sweep takes DEPTH-CLEAR_BASE cycles. If CLEAR_BASE>=DEPTH, the FSM goes to READY on the first cycle.
  - busy=1 and req_ready=0 throughout; ld_we is ignored (dropped, not queued).
- FSM state READY:
  - busy=0.
  - req_ready = !rsp_valid || rsp_ready (single-entry output register, full throughput).
- Fetch transfer (req_valid && req_ready):
  - Word index is req_pc[ADDR_W+1:2].
  - On the next edge: rsp_valid<=1, rsp_instr<=mem[index], rsp_err<=0.
  - Latency is exactly 1 cycle.
- Misaligned request (req_pc[1:0]!=0) or out of range (req_pc[31:ADDR_W+2]!=0):
  - rsp_instr<=0 (NOP), rsp_err<=1.
  - Still consumes one handshake.
- Response handshake:
  - rsp_valid && !rsp_ready: rsp_valid, rsp_instr and rsp_err hold stable.
  - rsp_ready && no new transfer: rsp_valid<=0.
  - Back-to-back transfers deliver one response per cycle.
- Load port (ld_we in READY):
  - mem[ld_addr]<=ld_data at the edge.
  - A same-cycle fetch of the same word returns the OLD data (read-before-write).
  - Loads are accepted regardless of fetch stall.
- Reset mid-operation:
  - Reset wins over everything; a pending response is discarded.
  - The sweep restarts from CLEAR_BASE.
  - A same-cycle ld_we is dropped.
- Memory has no initial contents in RTL other than those written by the load port. The bench loads the program through ld_*.

Optional Feature:
- Macro: IMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed on load writes and set to 0 for swept words.
  - On fetch, a recomputed parity mismatch sets rsp_err<=1 while rsp_instr still returns the stored data.
  - Adds a test-only input inj_par_flip (1 bit); a load with inj_par_flip==1 stores inverted parity.
- Undefined:
  - No parity storage and no inj_par_flip port.
  - rsp_err reflects only misalignment or range errors.

Test Plan:
- Reset with DEPTH=32, CLEAR_BASE=8 -> busy=1 for exactly 24 cycles then 0; rsp_valid=0; fetch pc=0x40 (word 16) returns 0x0000_0000, rsp_err=0.
- After the sweep, load word0=0x0232_8020 and word1=0x0232_8021; fetch pc=0 then pc=4 back-to-back with rsp_ready=1 -> responses 0x0232_8020 then 0x0232_8021 on consecutive cycles, 1-cycle latency.
- Fetch pc=0 with rsp_ready=0 for 3 cycles -> rsp_valid=1, rsp_instr stable at 0x0232_8020, req_ready=0; releasing rsp_ready accepts the next request.
- Fetch pc=0x06 -> rsp_err=1, rsp_instr=0; fetch pc=0x80 with DEPTH=32 -> rsp_err=1, rsp_instr=0.
- Same-cycle ld_we to word 2 (0xDEAD_BEEF) and fetch of pc=8 -> old value returned; a refetch returns 0xDEAD_BEEF.
- Assert reset mid-sweep at ptr=15 -> sweep restarts at 8 and busy lasts 24 cycles; with IMEM_PARITY_EN, a load using inj_par_flip=1 then fetched -> rsp_err=1.

Source files
------------

// File: rtl/ins_mem_fetch.sv
// Instruction memory with a valid/ready fetch port, a program-load port and a post-reset NOP sweep.
// Define IMEM_PARITY_EN to store a per-word even-parity bit and flag corrupted fetches on o_rsp_err.
module ins_mem_fetch #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 32,
  parameter int CLEAR_BASE = 8,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [31:0]       i_req_pc,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_instr,
  output logic              o_rsp_err,
  input  logic              i_ld_we,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_data,
`ifdef IMEM_PARITY_EN
  input  logic              i_inj_par_flip,
`endif
  output logic              o_busy
);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [31:0]       r_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_instr;
  logic              r_rsp_err;

  logic              w_ptr_last;
  logic              w_ptr_in_range;
  logic              w_xfer;
  logic              w_misalign;
  logic              w_out_of_range;
  logic [ADDR_W-1:0] w_idx;
  logic              w_par_err;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr;
  logic [DATA_W-1:0] w_mem_wdata;

  // A base at or past DEPTH means nothing to sweep: leave CLEAR on the first cycle.
  assign w_ptr_last     = (r_ptr >= 32'(DEPTH - 1));
  assign w_ptr_in_range = (r_ptr < 32'(DEPTH));

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= S_CLEAR;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_CLEAR: if (w_ptr_last) w_next_state = S_READY;
      S_READY: w_next_state = S_READY;
      default: w_next_state = S_CLEAR;
    endcase
  end

  always_comb begin
    o_busy      = (r_state == S_CLEAR);
    o_req_ready = (r_state == S_READY) && (!r_rsp_valid || i_rsp_ready);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_ptr <= 32'(CLEAR_BASE);
    end else if (r_state == S_CLEAR && !w_ptr_last) begin
      r_ptr <= r_ptr + 32'd1;
    end
  end

  // Single write port shared by the sweep and the loader; loads are dropped while sweeping.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = '0;
    w_mem_wdata = '0;
    if (i_reset) begin
      if (r_state == S_CLEAR) begin
        if (w_ptr_in_range) begin
          w_mem_we    = 1'b1;
          w_mem_waddr = r_ptr[ADDR_W-1:0];
        end
      end else if (i_ld_we) begin
        w_mem_we    = 1'b1;
        w_mem_waddr = i_ld_addr;
        w_mem_wdata = i_ld_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  assign w_xfer         = i_req_valid && o_req_ready;
  assign w_misalign     = (i_req_pc[1:0] != 2'b00);
  assign w_out_of_range = ((i_req_pc >> (ADDR_W + 2)) != 32'd0);
  assign w_idx          = i_req_pc[ADDR_W+1:2];

`ifdef IMEM_PARITY_EN
  logic r_par [DEPTH];
  logic w_mem_wpar;

  // Swept words hold zero data, so a zero parity bit is already consistent.
  assign w_mem_wpar = (r_state == S_CLEAR) ? 1'b0 : ((^i_ld_data) ^ i_inj_par_flip);

  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_par[w_mem_waddr] <= w_mem_wpar;
    end
  end

  assign w_par_err = ((^r_mem[w_idx]) != r_par[w_idx]);
`else
  assign w_par_err = 1'b0;
`endif

  // Single-entry response register; memory is read before any same-edge write lands.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_instr <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_xfer) begin
      r_rsp_valid <= 1'b1;
      if (w_misalign || w_out_of_range) begin
        r_rsp_instr <= '0;
        r_rsp_err   <= 1'b1;
      end else begin
        r_rsp_instr <= r_mem[w_idx];
        r_rsp_err   <= w_par_err;
      end
    end else if (i_rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_instr = r_rsp_instr;
  assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_ins_mem_fetch.sv
// Self-checking bench for ins_mem_fetch: sweep timing, table-driven fetches, stall, RBW and reset corners.
// Define IMEM_PARITY_EN here as for the RTL to exercise the parity error path.
module tb_ins_mem_fetch;

  localparam int DATA_W     = 32;
  localparam int DEPTH      = 32;
  localparam int CLEAR_BASE = 8;
  localparam int ADDR_W     = 5;

  logic              clk = 1'b0;
  logic              resetN;
  logic              reqValid;
  logic              reqReady;
  logic [31:0]       reqPc;
  logic              rspValid;
  logic              rspReady;
  logic [DATA_W-1:0] rspInstr;
  logic              rspErr;
  logic              ldWe;
  logic [ADDR_W-1:0] ldAddr;
  logic [DATA_W-1:0] ldData;
  logic              busy;
`ifdef IMEM_PARITY_EN
  logic              injParFlip;
`endif

  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  ins_mem_fetch #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .CLEAR_BASE(CLEAR_BASE)
  ) dut (
    .i_clk(clk),
    .i_reset(resetN),
    .i_req_valid(reqValid),
    .o_req_ready(reqReady),
    .i_req_pc(reqPc),
    .o_rsp_valid(rspValid),
    .i_rsp_ready(rspReady),
    .o_rsp_instr(rspInstr),
    .o_rsp_err(rspErr),
    .i_ld_we(ldWe),
    .i_ld_addr(ldAddr),
    .i_ld_data(ldData),
`ifdef IMEM_PARITY_EN
    .i_inj_par_flip(injParFlip),
`endif
    .o_busy(busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] pc, input logic rr);
    reqValid = rv;
    reqPc    = pc;
    rspReady = rr;
  endtask

  task automatic loadWord(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
    ldWe   = 1'b1;
    ldAddr = addr;
    ldData = data;
    tick();
    ldWe   = 1'b0;
  endtask

  // Counts cycles with busy high, starting from the cycle reset is released.
  task automatic waitSweep(input string name, input int expCycles);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    if (n >= 100) $display("[TB] FAIL %s: sweep never finished", name);
    checkOutput(name, 32'(n), 32'(expCycles));
  endtask

  task automatic fetchCheck(input string name, input logic [31:0] pc,
                            input logic [31:0] expInstr, input logic expErr);
    applyStimulus(1'b1, pc, 1'b1);
    tick();
    checkOutput({name, "_valid"}, 32'(rspValid), 32'd1);
    checkOutput({name, "_instr"}, rspInstr, expInstr);
    checkOutput({name, "_err"}, 32'(rspErr), 32'(expErr));
  endtask

  initial begin
    resetN   = 1'b0;
    ldWe     = 1'b0;
    ldAddr   = '0;
    ldData   = '0;
`ifdef IMEM_PARITY_EN
    injParFlip = 1'b0;
`endif
    applyStimulus(1'b0, 32'd0, 1'b1);

    // Power-on reset and first sweep
    repeat (3) tick();
    checkOutput("rst_valid", 32'(rspValid), 32'd0);
    checkOutput("rst_instr", rspInstr, 32'd0);
    checkOutput("rst_err", 32'(rspErr), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd1);
    checkOutput("rst_req_ready", 32'(reqReady), 32'd0);
    resetN = 1'b1;
    waitSweep("sweep1_cycles", DEPTH - CLEAR_BASE);
    checkOutput("ready_after_sweep", 32'(reqReady), 32'd1);
    fetchCheck("swept_word16", 32'h40, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b1);
    tick();

    loadWord(5'd0, 32'h0232_8020);
    loadWord(5'd1, 32'h0232_8021);
    loadWord(5'd2, 32'h1111_2222);
    loadWord(5'd3, 32'h0000_0013);
    loadWord(5'd4, 32'h4444_4444);
    loadWord(5'd5, 32'h5555_5555);
    loadWord(5'd16, 32'h1616_1616);

    // Back-to-back table of fetches, one per cycle
    vecs[0] = '{32'h0000_0000, 32'h0232_8020, 1'b0};
    vecs[1] = '{32'h0000_0004, 32'h0232_8021, 1'b0};
    vecs[2] = '{32'h0000_0006, 32'h0000_0000, 1'b1};
    vecs[3] = '{32'h0000_0080, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'h0000_000C, 32'h0000_0013, 1'b0};
    vecs[5] = '{32'h0000_0040, 32'h1616_1616, 1'b0};
    vecs[6] = '{32'h0000_0041, 32'h0000_0000, 1'b1};
    vecs[7] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b1};
    vecs[8] = '{32'h0000_007C, 32'h0000_0000, 1'b0};
    vecs[9] = '{32'h0000_0010, 32'h4444_4444, 1'b0};
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, vecs[i].pc, 1'b1);
      #1;
      checkOutput($sformatf("vec%0d_req_ready", i), 32'(reqReady), 32'd1);
      tick();
      checkOutput($sformatf("vec%0d_valid", i), 32'(rspValid), 32'd1);
      checkOutput($sformatf("vec%0d_instr", i), rspInstr, vecs[i].instr);
      checkOutput($sformatf("vec%0d_err", i), 32'(rspErr), 32'(vecs[i].err));
    end
    applyStimulus(1'b0, 32'd0, 1'b1);
    tick();
    checkOutput("idle_valid", 32'(rspValid), 32'd0);

    // Consumer stall holds the response and blocks new requests
    fetchCheck("stall_first", 32'h0, 32'h0232_8020, 1'b0);
    applyStimulus(1'b1, 32'h4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("stall%0d_req_ready", i), 32'(reqReady), 32'd0);
      tick();
      checkOutput($sformatf("stall%0d_valid", i), 32'(rspValid), 32'd1);
      checkOutput($sformatf("stall%0d_instr", i), rspInstr, 32'h0232_8020);
    end
    rspReady = 1'b1;
    #1;
    checkOutput("release_req_ready", 32'(reqReady), 32'd1);
    tick();
    checkOutput("release_instr", rspInstr, 32'h0232_8021);
    applyStimulus(1'b0, 32'd0, 1'b1);
    tick();
    checkOutput("drain_valid", 32'(rspValid), 32'd0);

    // Same-cycle load and fetch of word 2 returns the old word
    ldWe   = 1'b1;
    ldAddr = 5'd2;
    ldData = 32'hDEAD_BEEF;
    fetchCheck("rbw_old", 32'h8, 32'h1111_2222, 1'b0);
    ldWe = 1'b0;
    fetchCheck("rbw_new", 32'h8, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b1);
    tick();

`ifdef IMEM_PARITY_EN
    injParFlip = 1'b1;
    loadWord(5'd6, 32'h0000_0007);
    injParFlip = 1'b0;
    loadWord(5'd7, 32'h0000_0007);
    fetchCheck("parity_bad", 32'h18, 32'h0000_0007, 1'b1);
    fetchCheck("parity_good", 32'h1C, 32'h0000_0007, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b1);
    tick();
`endif

    // Reset discards a pending response
    applyStimulus(1'b1, 32'h0, 1'b0);
    tick();
    checkOutput("pending_valid", 32'(rspValid), 32'd1);
    applyStimulus(1'b0, 32'd0, 1'b0);
    resetN = 1'b0;
    tick();
    checkOutput("midrst_valid", 32'(rspValid), 32'd0);
    checkOutput("midrst_instr", rspInstr, 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd1);
    checkOutput("midrst_req_ready", 32'(reqReady), 32'd0);
    rspReady = 1'b1;
    resetN   = 1'b1;

    // Loads during the sweep are dropped; reset again at ptr==15
    ldWe   = 1'b1;
    ldAddr = 5'd4;
    ldData = 32'hBAD0_0000;
    repeat (7) tick();
    checkOutput("mid_sweep_busy", 32'(busy), 32'd1);
    ldAddr = 5'd5;
    resetN = 1'b0;
    tick();
    ldWe   = 1'b0;
    resetN = 1'b1;
    waitSweep("sweep_restart_cycles", DEPTH - CLEAR_BASE);
    fetchCheck("sweep_drop_ld4", 32'h10, 32'h4444_4444, 1'b0);
    fetchCheck("rst_drop_ld5", 32'h14, 32'h5555_5555, 1'b0);
    fetchCheck("preserved_word3", 32'h0C, 32'h0000_0013, 1'b0);
    fetchCheck("reswept_word16", 32'h40, 32'h0000_0000, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
